// File: rtl/pipe_ctrl_if.sv
// Purpose : groups the hazard-detector strobes, halt/go and the pipeline control outputs of pipe_ctrl.
// Latency : n/a (wires only).
// Backpressure: none; stalls are expressed through pc_en/fd_en/clears.
// Signals : LOADUSE, BRANCH, E_Rs, M_Rs, E_Rt, M_Rt, halt, go   (master -> slave)
//           pc_en, fd_en, fd_clr, de_clr, fwd_a, fwd_b, halted,
//           stall_cnt, flush_cnt, cycle_cnt                      (slave -> master)
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             LOADUSE;
  logic             BRANCH;
  logic             E_Rs;
  logic             M_Rs;
  logic             E_Rt;
  logic             M_Rt;
  logic             halt;
  logic             go;
  logic             pc_en;
  logic             fd_en;
  logic             fd_clr;
  logic             de_clr;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] cycle_cnt;

  // Driver of the strobes (hazard detector / ID stage side).
  modport master (
    output LOADUSE, BRANCH, E_Rs, M_Rs, E_Rt, M_Rt, halt, go,
    input  pc_en, fd_en, fd_clr, de_clr, fwd_a, fwd_b, halted,
    input  stall_cnt, flush_cnt, cycle_cnt
  );

  // The control stage itself.
  modport slave (
    input  LOADUSE, BRANCH, E_Rs, M_Rs, E_Rt, M_Rt, halt, go,
    output pc_en, fd_en, fd_clr, de_clr, fwd_a, fwd_b, halted,
    output stall_cnt, flush_cnt, cycle_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Purpose : pipeline control downstream of the hazard detector: PC/IF-ID/ID-EX enables and
//           clears, ALU forwarding selects, syscall-halt drain sequencer, optional statistics.
// Latency : control and forwarding outputs are combinational from the current strobes/state;
//           state moves on the next rising clk edge; counters show an event one cycle later.
// Backpressure: none accepted; this block creates stalls (pc_en/fd_en low) and bubbles (clears).
// Ports   : clk, rst_n (async active-low); pif (pipe_ctrl_if.slave) carrying the strobes,
//           halt/go, the enables/clears, fwd_a/fwd_b, halted and the three statistics counters.
// Options : define PIPE_STATS_EN to build the saturating stall/flush/cycle counters;
//           otherwise the counter outputs read 0 and no counter flops exist.
module pipe_ctrl #(
  parameter int DRAIN_CYC = 3,   // 1..15
  parameter int CNT_W     = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_ctrl_if.slave pif
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DRAIN = 2'b01,
    HALT  = 2'b10
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYC - 1);

  state_t     state_q, state_d;
  logic [3:0] drain_q, drain_d;

  logic pc_en, fd_en, fd_clr, de_clr, halted;

  // Forwarding is independent of FSM state; the EX-stage match is the younger
  // producer, so it wins over MEM.
  assign pif.fwd_a = pif.E_Rs ? 2'b01 : (pif.M_Rs ? 2'b10 : 2'b00);
  assign pif.fwd_b = pif.E_Rt ? 2'b01 : (pif.M_Rt ? 2'b10 : 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    pc_en   = 1'b1;
    fd_en   = 1'b1;
    fd_clr  = 1'b0;
    de_clr  = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (pif.BRANCH) begin
          // A stalled instruction under a taken branch is wrong-path: flush, don't stall.
          fd_clr = 1'b1;
          de_clr = 1'b1;
        end else if (pif.LOADUSE) begin
          pc_en  = 1'b0;
          fd_en  = 1'b0;
          de_clr = 1'b1;
        end else if (pif.halt) begin
          // Halt only counts on a clean cycle; otherwise the instruction re-presents it.
          state_d = DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        // Older instructions keep retiring while fetch is frozen and IF/ID filled with bubbles.
        pc_en  = 1'b0;
        fd_clr = 1'b1;
        if (drain_q == 4'd0) state_d = HALT;
        else                 drain_d = drain_q - 4'd1;
      end
      HALT: begin
        pc_en  = 1'b0;
        fd_en  = 1'b0;
        de_clr = 1'b1;
        halted = 1'b1;
        if (pif.go) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign pif.pc_en  = pc_en;
  assign pif.fd_en  = fd_en;
  assign pif.fd_clr = fd_clr;
  assign pif.de_clr = de_clr;
  assign pif.halted = halted;

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [CNT_W-1:0] cyc_q,   cyc_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    stall_d = sat_inc(stall_q, (state_q == RUN) && pif.LOADUSE && !pif.BRANCH);
    flush_d = sat_inc(flush_q, (state_q == RUN) && pif.BRANCH);
    cyc_d   = sat_inc(cyc_q,   (state_q == RUN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
      cyc_q   <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
      cyc_q   <= cyc_d;
    end
  end

  assign pif.stall_cnt = stall_q;
  assign pif.flush_cnt = flush_q;
  assign pif.cycle_cnt = cyc_q;
`else
  assign pif.stall_cnt = '0;
  assign pif.flush_cnt = '0;
  assign pif.cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Purpose : self-checking bench for pipe_ctrl; a reference model pushes expected outputs to a
//           scoreboard queue as each cycle's stimulus is driven, and each test pops and compares.
// Latency : outputs sampled 2 time units after the falling edge, well away from the rising edge.
// Backpressure: n/a.
module tb_pipe_ctrl;
  localparam int DRAIN_CYC = 3;
  localparam int CNT_W     = 4;
`ifdef PIPE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // Stimulus vector bit positions: {LOADUSE, BRANCH, E_Rs, M_Rs, E_Rt, M_Rt, halt, go}
  localparam logic [7:0] LU = 8'h80, BR = 8'h40, ERS = 8'h20, MRS = 8'h10,
                         ERT = 8'h08, MRT = 8'h04, HLT = 8'h02, GO = 8'h01, IDLE = 8'h00;

  typedef enum logic [1:0] {M_RUN, M_DRAIN, M_HALT} mst_t;

  typedef struct packed {
    logic             pc_en;
    logic             fd_en;
    logic             fd_clr;
    logic             de_clr;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             halted;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
    logic [CNT_W-1:0] cyc;
  } out_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CNT_W)) pif ();

  pipe_ctrl #(.DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .pif  (pif)
  );

  out_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mst_t             m_st;
  int               m_dcnt;
  logic [CNT_W-1:0] m_stall, m_flush, m_cyc;

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  task automatic model_reset();
    m_st    = M_RUN;
    m_dcnt  = 0;
    m_stall = '0;
    m_flush = '0;
    m_cyc   = '0;
  endtask

  function automatic out_t model_out(input logic [7:0] v);
    out_t o;
    o.fwd_a  = v[5] ? 2'b01 : (v[4] ? 2'b10 : 2'b00);
    o.fwd_b  = v[3] ? 2'b01 : (v[2] ? 2'b10 : 2'b00);
    o.stall  = m_stall;
    o.flush  = m_flush;
    o.cyc    = m_cyc;
    o.halted = 1'b0;
    case (m_st)
      M_RUN: begin
        if (v[6])      {o.pc_en, o.fd_en, o.fd_clr, o.de_clr} = 4'b1111;
        else if (v[7]) {o.pc_en, o.fd_en, o.fd_clr, o.de_clr} = 4'b0001;
        else           {o.pc_en, o.fd_en, o.fd_clr, o.de_clr} = 4'b1100;
      end
      M_DRAIN: {o.pc_en, o.fd_en, o.fd_clr, o.de_clr} = 4'b0110;
      default: begin
        {o.pc_en, o.fd_en, o.fd_clr, o.de_clr} = 4'b0001;
        o.halted = 1'b1;
      end
    endcase
    return o;
  endfunction

  // Advance the model across one rising edge.
  task automatic model_step(input logic [7:0] v);
    case (m_st)
      M_RUN: begin
        if (STATS) begin
          m_cyc = sat(m_cyc);
          if (v[6])      m_flush = sat(m_flush);
          else if (v[7]) m_stall = sat(m_stall);
        end
        if (v[1] && !v[6] && !v[7]) begin
          m_st   = M_DRAIN;
          m_dcnt = DRAIN_CYC - 1;
        end
      end
      M_DRAIN: begin
        if (m_dcnt == 0) m_st = M_HALT;
        else             m_dcnt = m_dcnt - 1;
      end
      default: if (v[0]) m_st = M_RUN;
    endcase
  endtask

  function automatic out_t observed();
    out_t o;
    o.pc_en  = pif.pc_en;
    o.fd_en  = pif.fd_en;
    o.fd_clr = pif.fd_clr;
    o.de_clr = pif.de_clr;
    o.fwd_a  = pif.fwd_a;
    o.fwd_b  = pif.fwd_b;
    o.halted = pif.halted;
    o.stall  = pif.stall_cnt;
    o.flush  = pif.flush_cnt;
    o.cyc    = pif.cycle_cnt;
    return o;
  endfunction

  task automatic set_inputs(input logic [7:0] v);
    {pif.LOADUSE, pif.BRANCH, pif.E_Rs, pif.M_Rs, pif.E_Rt, pif.M_Rt, pif.halt, pif.go} = v;
  endtask

  // Drive one cycle of stimulus on the falling edge, record the expected outputs,
  // then wait to the sample point.
  task automatic drive(input logic [7:0] v);
    @(negedge clk);
    set_inputs(v);
    exp_q.push_back(model_out(v));
    model_step(v);
    #2;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    set_inputs(IDLE);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    out_t got, want;
    set_inputs(IDLE);
    rst_n = 1'b0;
    model_reset();
    #1;
    exp_q.push_back(model_out(IDLE));
    got = observed(); want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", got, want);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Enter DRAIN, then abort it with an asynchronous reset between edges.
    drive(HLT);
    got = observed(); want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_halt_cycle: got %h want %h", got, want);
    end
    drive(IDLE);
    got = observed(); want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_in_drain: got %h want %h", got, want);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    exp_q.push_back(model_out(IDLE));
    got = observed(); want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL reset_mid_drain: got %h want %h", got, want);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    logic [7:0] tbl [5] = '{LU, LU, IDLE, IDLE, LU | ERS};
    out_t got, want;
    foreach (tbl[i]) begin
      drive(tbl[i]);
      got = observed(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL load_use[%0d]: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_branch_priority();
    logic [7:0] tbl [5] = '{LU | BR, IDLE, BR, BR | LU | MRT, IDLE};
    out_t got, want;
    foreach (tbl[i]) begin
      drive(tbl[i]);
      got = observed(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL branch_priority[%0d]: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_forwarding();
    out_t got, want;
    drive(ERS | MRS | MRT);
    got = observed(); want = exp_q.pop_front(); n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL fwd_pattern: got %h want %h", got, want);
    end
    for (int k = 0; k < 16; k++) begin
      drive(8'(k << 2));
      got = observed(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL fwd_sweep[%0d]: got %h want %h", k, got, want);
      end
    end
  endtask

  task automatic test_halt();
    // Halt alongside a strobe is ignored; then a clean halt drains for DRAIN_CYC cycles.
    // go and strobes during DRAIN are ignored; forwarding keeps working while halted.
    logic [7:0] tbl [14] = '{BR | HLT, LU | HLT, IDLE, HLT, GO, LU | BR | GO, GO | ERS,
                             IDLE, MRS | ERT, IDLE, GO, IDLE, IDLE, IDLE};
    out_t got, want;
    foreach (tbl[i]) begin
      drive(tbl[i]);
      got = observed(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL halt_seq[%0d]: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_saturation();
    out_t got, want;
    pulse_reset();
    for (int k = 0; k < 20; k++) begin
      drive(k < 18 ? LU : BR);
      got = observed(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL saturation[%0d]: got %h want %h", k, got, want);
      end
    end
    drive(IDLE);
    got = observed(); void'(exp_q.pop_front()); n_checks++;
    if (got.cyc !== (STATS ? 4'hF : 4'h0) || got.stall !== (STATS ? 4'hF : 4'h0)) begin
      n_fail++;
      $display("FAIL sat_final: got cyc=%0d stall=%0d want %0d", got.cyc, got.stall,
               STATS ? 15 : 0);
    end
  endtask

  task automatic test_back_to_back();
    out_t       got, want;
    logic [7:0] v;
    pulse_reset();
    for (int k = 0; k < 60; k++) begin
      v = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) != 0) v[1] = 1'b0;   // keep halts rare so RUN dominates
      drive(v);
      got = observed(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL back_to_back[%0d] in=%h: got %h want %h", k, v, got, want);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_use();
    test_branch_priority();
    test_forwarding();
    test_halt();
    test_saturation();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
